data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit RAM words (power of 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: console TX FIFO entries (power of 2, ≥2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port MemWriteM  input  1  write strobe from the core's memory stage.
REQ-006 SHALL have port ALUOutM  input  32  byte address from the core.
REQ-007 SHALL have port WriteDataM  input  32  store data from the core.
REQ-008 SHALL have port ReadDataM  output  32  load data returned to the core.
REQ-009 SHALL have port cons_valid  output  1  console byte available.
REQ-010 SHALL have port cons_data  output  8  console byte (FIFO head).
REQ-011 SHALL have port cons_ready  input  1  console consumer accepts byte.

Function
REQ-012 SHALL decode the address with ALUOutM[1:0] ignored (word access only).
REQ-013 SHALL map RAM at 0x0000_0000 to DEPTH_WORDS*4-1; MMIO at 0x8000_0000 TXDATA, 0x8000_0004 STATUS, 0x8000_0008 CYCLE, 0x8000_000C ERR; everything else out of range.
REQ-014 SHALL drive ReadDataM combinationally from the current address in the same cycle (zero-latency read), with no stall signal to the core.
REQ-015 SHALL commit writes at the rising edge when MemWriteM=1; a read of the same address in the same cycle returns the old value.
REQ-016 SHALL return 0 from TXDATA reads and from out-of-range reads.
REQ-017 SHALL return STATUS = {count in bits[7:4], empty in bit1, full in bit0}, other bits 0.
REQ-018 SHALL push WriteDataM[7:0] into the FIFO on a TXDATA write when not full, or when full and a pop occurs in the same cycle (count unchanged).
REQ-019 SHALL drop a TXDATA write when full with no pop in that cycle, and set ERR[0].
REQ-020 SHALL assert cons_valid whenever count>0, with cons_data = the oldest entry; pop when cons_valid&&cons_ready.
REQ-021 SHALL hold cons_data stable while cons_valid=1 and cons_ready=0.
REQ-022 SHALL on simultaneous push and pop with 0<count<FIFO_DEPTH keep count unchanged and preserve order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL increment CYCLE by 1 every cycle out of reset, wrapping 0xFFFF_FFFF→0.
REQ-024 SHALL, on a CYCLE write, load WriteDataM, taking precedence over the increment; the next cycle shows WriteDataM+1.
REQ-025 SHALL set ERR[1] on any out-of-range read or write; the write itself has no effect.
REQ-026 SHALL clear each ERR bit written with 1 on an ERR write; a same-cycle set wins over the clear.

Reset
REQ-027 SHALL, while reset=0 at a rising edge, clear FIFO pointers/count, CYCLE, and ERR; RAM contents are unaffected.
REQ-028 SHALL force ReadDataM=0 and cons_valid=0 while reset=0; cons_data is don't-care.
REQ-029 SHALL ignore MemWriteM during reset; an entry mid-handshake is discarded.

Configuration
REQ-030 SHALL include the CYCLE counter only when DMEM_CYCLE_COUNTER_EN is defined; without it, CYCLE reads return 0, CYCLE writes are ignored and do not set ERR, and no counter flops exist.

Verification
REQ-031 SHALL cover: write 0x12345678 to 0x10, then read 0x10 -> ReadDataM=0x12345678; read 0x13 -> same value.
REQ-032 SHALL cover: cons_ready=0, write 0x41..0x48 to TXDATA -> STATUS=0x81; a ninth write 0x49 -> dropped, ERR=0x1; cons_ready=1 -> bytes 0x41..0x48 emitted in order, then STATUS=0x02.
REQ-033 SHALL cover: FIFO full with cons_ready=1 and a TXDATA write of 0x5A in the same cycle -> count stays 8, ERR[0]=0, 0x5A emitted last.
REQ-034 SHALL cover (macro defined): write 0xFFFF_FFFE to CYCLE -> reads over the next cycles return 0xFFFF_FFFF, then 0x0000_0000; (macro undefined) -> reads return 0.
REQ-035 SHALL cover: read 0x4000_0000 -> ReadDataM=0, ERR=0x2; write 0x2 to ERR -> ERR=0.
REQ-036 SHALL cover: reset=0 asserted with 3 FIFO entries pending -> the next cycle shows cons_valid=0, STATUS=0x02, CYCLE=0, while RAM[0x10] still reads 0x12345678.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Zero-latency data-memory responder for a pipelined core.
//               Word-addressed RAM plus an MMIO block. The MMIO block holds
//               a console TX FIFO, a status register, an optional free-running
//               cycle counter and sticky error flags.
//
//               Address map (byte addresses, ALUOutM[1:0] ignored):
//                 0x0000_0000 .. DEPTH_WORDS*4-1  RAM
//                 0x8000_0000  TXDATA  (W: push byte, R: 0)
//                 0x8000_0004  STATUS  {count[7:4], empty[1], full[0]}
//                 0x8000_0008  CYCLE   (R/W cycle counter)
//                 0x8000_000C  ERR     {oor[1], tx_drop[0]}, write-1-to-clear
//                 anything else        out of range (reads 0, sets ERR[1])
//
//               Optional feature macro: DMEM_CYCLE_COUNTER_EN
//                 defined   -> CYCLE counter present
//                 undefined -> CYCLE reads 0, writes ignored, no counter flops
//
// Ports       : clk          clock, all state changes on its rising edge
//               reset        synchronous active-low reset
//               MemWriteM    write strobe from the core's memory stage
//               ALUOutM      byte address
//               WriteDataM   store data
//               ReadDataM    combinational load data
//               cons_valid   console byte available (FIFO not empty)
//               cons_data    console byte (FIFO head)
//               cons_ready   console consumer accepts the byte
//
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready
);

    localparam int                 c_RAM_AW    = $clog2(DEPTH_WORDS);
    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [29:0]        c_RAM_WORDS = 30'(DEPTH_WORDS);
    // MMIO registers as word addresses (byte address >> 2)
    localparam logic [29:0]        c_TXDATA_W  = 30'h2000_0000;
    localparam logic [29:0]        c_STATUS_W  = 30'h2000_0001;
    localparam logic [29:0]        c_CYCLE_W   = 30'h2000_0002;
    localparam logic [29:0]        c_ERR_W     = 30'h2000_0003;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]         w_word_addr;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic                w_unused_addr_lsbs;
    logic                w_hit_ram;
    logic                w_hit_tx;
    logic                w_hit_status;
    logic                w_hit_cycle;
    logic                w_hit_err;
    logic                w_hit_oor;

    assign w_word_addr        = ALUOutM[31:2];
    assign w_ram_idx          = ALUOutM[c_RAM_AW+1:2];
    assign w_unused_addr_lsbs = ^ALUOutM[1:0];

    assign w_hit_ram    = (w_word_addr < c_RAM_WORDS);
    assign w_hit_tx     = (w_word_addr == c_TXDATA_W);
    assign w_hit_status = (w_word_addr == c_STATUS_W);
    assign w_hit_cycle  = (w_word_addr == c_CYCLE_W);
    assign w_hit_err    = (w_word_addr == c_ERR_W);
    // CYCLE stays a legal address even when the counter is compiled out
    assign w_hit_oor    = !(w_hit_ram || w_hit_tx || w_hit_status ||
                            w_hit_cycle || w_hit_err);

    // Writes are ignored while reset is asserted
    logic w_wr;
    assign w_wr = MemWriteM && reset;

    // ------------------------------------------------------------------
    // RAM (no reset: contents survive reset)
    // ------------------------------------------------------------------
    logic [31:0] r_ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (w_wr && w_hit_ram) begin
            r_ram[w_ram_idx] <= WriteDataM;
        end
    end

    // ------------------------------------------------------------------
    // Console TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_tx_wr;
    logic               w_push;
    logic               w_drop;

    assign w_full     = (r_count == c_FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign cons_valid = reset && !w_empty;
    assign cons_data  = r_fifo[r_rd_ptr];
    assign w_pop      = cons_valid && cons_ready;
    assign w_tx_wr    = w_wr && w_hit_tx;
    // When full, a same-cycle pop frees the slot the write pointer points at
    assign w_push     = w_tx_wr && (!w_full || w_pop);
    assign w_drop     = w_tx_wr && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= WriteDataM[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Error flags: bit0 = dropped TX byte, bit1 = out-of-range access.
    // Set wins over a same-cycle write-1-to-clear.
    // ------------------------------------------------------------------
    logic [1:0] r_err;
    logic [1:0] w_err_set;
    logic [1:0] w_err_clr;

    assign w_err_set = {reset && w_hit_oor, w_drop};
    assign w_err_clr = (w_wr && w_hit_err) ? WriteDataM[1:0] : 2'b00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
            r_err <= (r_err & ~w_err_clr) | w_err_set;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter (optional)
    // ------------------------------------------------------------------
    logic [31:0] w_cycle_rd;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle <= '0;
        end else if (w_wr && w_hit_cycle) begin
            r_cycle <= WriteDataM;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle_rd = r_cycle;
`else
    assign w_cycle_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Combinational read mux (forced to 0 during reset)
    // ------------------------------------------------------------------
    logic [3:0]  w_count4;
    logic [31:0] w_rdata;

    assign w_count4 = 4'(r_count);

    always_comb begin
        w_rdata = '0;
        if (reset) begin
            if (w_hit_ram) begin
                w_rdata = r_ram[w_ram_idx];
            end else if (w_hit_status) begin
                w_rdata = {24'd0, w_count4, 2'b00, w_empty, w_full};
            end else if (w_hit_cycle) begin
                w_rdata = w_cycle_rd;
            end else if (w_hit_err) begin
                w_rdata = {30'd0, r_err};
            end
        end
    end

    assign ReadDataM = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. A queue/array
//               reference model tracks RAM, console FIFO, ERR and CYCLE.
//               Inputs change 1 ns after the rising edge; outputs are
//               sampled 1 ns later, well away from the edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int          DEPTH_WORDS = 64;
    localparam int          FIFO_DEPTH  = 8;
    localparam logic [31:0] A_TX        = 32'h8000_0000;
    localparam logic [31:0] A_ST        = 32'h8000_0004;
    localparam logic [31:0] A_CY        = 32'h8000_0008;
    localparam logic [31:0] A_ER        = 32'h8000_000C;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        MemWriteM  = 1'b0;
    logic [31:0] ALUOutM    = '0;
    logic [31:0] WriteDataM = '0;
    logic        cons_ready = 1'b0;
    logic [31:0] ReadDataM;
    logic        cons_valid;
    logic [7:0]  cons_data;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0]  m_ram [DEPTH_WORDS];
    byte unsigned m_q[$];
    logic [1:0]   m_err   = 2'b00;
    logic [31:0]  m_cycle = '0;
    int           n_checks = 0;
    int           n_errors = 0;

    // 0 RAM, 1 TXDATA, 2 STATUS, 3 CYCLE, 4 ERR, 5 out of range
    function automatic int region(input logic [31:0] a);
        if (a < 32'(DEPTH_WORDS * 4)) return 0;
        case (a & ~32'h3)
            A_TX:    return 1;
            A_ST:    return 2;
            A_CY:    return 3;
            A_ER:    return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] s;
        if (!reset) return 32'd0;
        case (region(a))
            0: return m_ram[int'(a >> 2)];
            2: begin
                s = 32'(m_q.size()) << 4;
                if (m_q.size() == 0)          s = s | 32'h2;
                if (m_q.size() == FIFO_DEPTH) s = s | 32'h1;
                return s;
            end
`ifdef DMEM_CYCLE_COUNTER_EN
            3: return m_cycle;
`endif
            4: return {30'd0, m_err};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the currently driven inputs,
    // then step past the rising edge.
    task automatic tick();
        int         r;
        bit         pop;
        bit         drop;
        logic [1:0] clr;
        if (!reset) begin
            m_q.delete();
            m_err   = 2'b00;
            m_cycle = '0;
        end else begin
            r    = region(ALUOutM);
            pop  = cons_ready && (m_q.size() > 0);
            drop = 1'b0;
            clr  = 2'b00;
`ifdef DMEM_CYCLE_COUNTER_EN
            m_cycle = (MemWriteM && r == 3) ? WriteDataM : m_cycle + 32'd1;
`endif
            if (pop) void'(m_q.pop_front());
            if (MemWriteM) begin
                case (r)
                    0: m_ram[int'(ALUOutM >> 2)] = WriteDataM;
                    1: if (m_q.size() < FIFO_DEPTH) m_q.push_back(WriteDataM[7:0]);
                       else drop = 1'b1;
                    4: clr = WriteDataM[1:0];
                    default: ;
                endcase
            end
            m_err = (m_err & ~clr) | {(r == 5), drop};
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; ALUOutM = A_ST; MemWriteM = 1'b0; cons_ready = 1'b0;
        tick(); tick();
        #1;
        n_checks++;
        if (ReadDataM !== 32'd0) begin n_errors++; $display("FAIL rst_rdata got %h exp %h", ReadDataM, 32'd0); end
        n_checks++;
        if (cons_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b exp 0", cons_valid); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ReadDataM !== 32'h2) begin n_errors++; $display("FAIL rst_status got %h exp %h", ReadDataM, 32'h2); end
        ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL rst_err got %h exp 0", ReadDataM); end
        ALUOutM = A_CY; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL rst_cycle got %h exp 0", ReadDataM); end
        ALUOutM = 32'h0;
    endtask

    task automatic test_ram();
        logic [31:0] a;
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            ALUOutM = 32'(i * 4); MemWriteM = 1'b1; WriteDataM = $urandom;
            tick();
        end
        ALUOutM = 32'h10; WriteDataM = 32'h1234_5678; tick();
        MemWriteM = 1'b0; #1;
        n_checks++;
        if (ReadDataM !== 32'h1234_5678) begin n_errors++; $display("FAIL ram_0x10 got %h exp %h", ReadDataM, 32'h1234_5678); end
        ALUOutM = 32'h13; #1;
        n_checks++;
        if (ReadDataM !== 32'h1234_5678) begin n_errors++; $display("FAIL ram_0x13 got %h exp %h", ReadDataM, 32'h1234_5678); end
        // random mix; a read during a write must return the old word
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, DEPTH_WORDS * 4 - 1));
            ALUOutM = a; MemWriteM = 1'($urandom_range(0, 1)); WriteDataM = $urandom;
            #1;
            n_checks++;
            if (ReadDataM !== exp_read(a)) begin n_errors++; $display("FAIL ram_rand addr %h got %h exp %h", a, ReadDataM, exp_read(a)); end
            tick();
        end
        ALUOutM = 32'h10; MemWriteM = 1'b1; WriteDataM = 32'h1234_5678; tick();
        MemWriteM = 1'b0; ALUOutM = 32'h0;
    endtask

    task automatic test_fifo_order();
        cons_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h48; b++) begin
            ALUOutM = A_TX; MemWriteM = 1'b1;
            WriteDataM = ($urandom & 32'hFFFF_FF00) | 32'(b);
            tick();
            n_checks++;
            if (cons_valid !== 1'b1 || cons_data !== 8'h41) begin
                n_errors++; $display("FAIL fifo_hold valid %b data %h exp 1 %h", cons_valid, cons_data, 8'h41);
            end
        end
        MemWriteM = 1'b0; ALUOutM = A_ST; #1;
        n_checks++;
        if (ReadDataM !== 32'h81) begin n_errors++; $display("FAIL fifo_full_status got %h exp %h", ReadDataM, 32'h81); end
        ALUOutM = A_TX; MemWriteM = 1'b1; WriteDataM = 32'h49; tick();
        MemWriteM = 1'b0; ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h1) begin n_errors++; $display("FAIL fifo_drop_err got %h exp %h", ReadDataM, 32'h1); end
        ALUOutM = A_ST; cons_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (cons_valid !== 1'b1 || cons_data !== 8'(8'h41 + k)) begin
                n_errors++; $display("FAIL fifo_order idx %0d valid %b data %h exp %h", k, cons_valid, cons_data, 8'(8'h41 + k));
            end
            tick();
        end
        #1;
        n_checks++;
        if (ReadDataM !== 32'h2) begin n_errors++; $display("FAIL fifo_empty_status got %h exp %h", ReadDataM, 32'h2); end
        ALUOutM = A_ER; MemWriteM = 1'b1; WriteDataM = 32'h1; tick();
        MemWriteM = 1'b0; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL err_clear got %h exp 0", ReadDataM); end
        cons_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        cons_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ALUOutM = A_TX; MemWriteM = 1'b1; WriteDataM = 32'($urandom_range(0, 255));
            tick();
        end
        WriteDataM = 32'h5A; cons_ready = 1'b1; #1;
        n_checks++;
        if (cons_data !== m_q[0]) begin n_errors++; $display("FAIL fp_head got %h exp %h", cons_data, m_q[0]); end
        tick();
        MemWriteM = 1'b0; cons_ready = 1'b0; ALUOutM = A_ST; #1;
        n_checks++;
        if (ReadDataM !== 32'h81) begin n_errors++; $display("FAIL fp_status got %h exp %h", ReadDataM, 32'h81); end
        ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL fp_err got %h exp 0", ReadDataM); end
        cons_ready = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            #1;
            n_checks++;
            if (cons_valid !== 1'b1 || cons_data !== m_q[0]) begin
                n_errors++; $display("FAIL fp_drain idx %0d got %h exp %h", k, cons_data, m_q[0]);
            end
            if (k == FIFO_DEPTH - 1) begin
                n_checks++;
                if (cons_data !== 8'h5A) begin n_errors++; $display("FAIL fp_last got %h exp %h", cons_data, 8'h5A); end
            end
            tick();
        end
        #1;
        n_checks++;
        if (cons_valid !== 1'b0) begin n_errors++; $display("FAIL fp_empty valid %b exp 0", cons_valid); end
        cons_ready = 1'b0;
    endtask

    task automatic test_random_traffic();
        int op;
        for (int i = 0; i < 300; i++) begin
            cons_ready = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 9);
            MemWriteM = 1'b0; WriteDataM = $urandom;
            case (op)
                0, 1, 2, 3, 4: begin ALUOutM = A_TX; MemWriteM = 1'b1; end
                5, 6:          ALUOutM = A_ST;
                7:             ALUOutM = A_ER;
                8:             begin ALUOutM = A_ER; MemWriteM = 1'($urandom_range(0, 1)); end
                default:       ALUOutM = 32'($urandom_range(0, DEPTH_WORDS * 4 - 1));
            endcase
            #1;
            n_checks++;
            if (cons_valid !== (m_q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, cons_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                n_checks++;
                if (cons_data !== m_q[0]) begin n_errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, cons_data, m_q[0]); end
            end
            n_checks++;
            if (ReadDataM !== exp_read(ALUOutM)) begin n_errors++; $display("FAIL rnd_rdata cyc %0d addr %h got %h exp %h", i, ALUOutM, ReadDataM, exp_read(ALUOutM)); end
            tick();
        end
        MemWriteM = 1'b0; ALUOutM = A_ST; cons_ready = 1'b1;
        for (int i = 0; i < FIFO_DEPTH + 2 && m_q.size() != 0; i++) tick();
        n_checks++;
        if (cons_valid !== 1'b0 || m_q.size() != 0) begin n_errors++; $display("FAIL rnd_drain valid %b left %0d exp 0", cons_valid, m_q.size()); end
        ALUOutM = A_ER; MemWriteM = 1'b1; WriteDataM = 32'h3; tick();
        MemWriteM = 1'b0; cons_ready = 1'b0;
    endtask

    task automatic test_cycle();
        ALUOutM = A_CY; MemWriteM = 1'b1; WriteDataM = 32'hFFFF_FFFE; tick();
        MemWriteM = 1'b0;
`ifdef DMEM_CYCLE_COUNTER_EN
        #1;
        n_checks++;
        if (ReadDataM !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL cyc_load got %h exp %h", ReadDataM, 32'hFFFF_FFFE); end
        tick();
        n_checks++;
        if (ReadDataM !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cyc_max got %h exp %h", ReadDataM, 32'hFFFF_FFFF); end
        tick();
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL cyc_wrap got %h exp 0", ReadDataM); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (ReadDataM !== m_cycle) begin n_errors++; $display("FAIL cyc_run got %h exp %h", ReadDataM, m_cycle); end
        end
`else
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL cyc_off got %h exp 0", ReadDataM); end
            tick();
        end
`endif
        ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL cyc_err got %h exp 0", ReadDataM); end
    endtask

    task automatic test_err();
        ALUOutM = 32'h4000_0000; MemWriteM = 1'b0; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL oor_rdata got %h exp 0", ReadDataM); end
        tick();
        ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h2) begin n_errors++; $display("FAIL oor_err got %h exp %h", ReadDataM, 32'h2); end
        MemWriteM = 1'b1; WriteDataM = 32'h2; tick();
        MemWriteM = 1'b0; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL err_w1c got %h exp 0", ReadDataM); end
        // first byte past RAM: write must not alias onto word 0
        ALUOutM = 32'(DEPTH_WORDS * 4); MemWriteM = 1'b1; WriteDataM = 32'hDEAD_BEEF; tick();
        MemWriteM = 1'b0; ALUOutM = 32'h0; #1;
        n_checks++;
        if (ReadDataM !== m_ram[0]) begin n_errors++; $display("FAIL oor_wr_ram got %h exp %h", ReadDataM, m_ram[0]); end
        ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h2) begin n_errors++; $display("FAIL oor_wr_err got %h exp %h", ReadDataM, 32'h2); end
        MemWriteM = 1'b1; WriteDataM = 32'h3; tick();
        MemWriteM = 1'b0; ALUOutM = 32'h8000_0010; tick();
        ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h2) begin n_errors++; $display("FAIL oor_mmio got %h exp %h", ReadDataM, 32'h2); end
        MemWriteM = 1'b1; WriteDataM = 32'h3; tick();
        MemWriteM = 1'b0; ALUOutM = 32'(DEPTH_WORDS * 4 - 4); tick();
        ALUOutM = A_ER; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL last_word_err got %h exp 0", ReadDataM); end
    endtask

    task automatic test_reset_midstream();
        cons_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ALUOutM = A_TX; MemWriteM = 1'b1; WriteDataM = 32'($urandom_range(0, 255));
            tick();
        end
        reset = 1'b0; ALUOutM = 32'h10; MemWriteM = 1'b1; WriteDataM = 32'hCAFE_F00D; cons_ready = 1'b1;
        #1;
        n_checks++;
        if (cons_valid !== 1'b0 || ReadDataM !== 32'h0) begin
            n_errors++; $display("FAIL mid_rst valid %b rdata %h exp 0 0", cons_valid, ReadDataM);
        end
        tick();
        reset = 1'b1; MemWriteM = 1'b0; cons_ready = 1'b0; ALUOutM = A_ST; #1;
        n_checks++;
        if (cons_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid got %b exp 0", cons_valid); end
        n_checks++;
        if (ReadDataM !== 32'h2) begin n_errors++; $display("FAIL mid_status got %h exp %h", ReadDataM, 32'h2); end
        ALUOutM = A_CY; #1;
        n_checks++;
        if (ReadDataM !== 32'h0) begin n_errors++; $display("FAIL mid_cycle got %h exp 0", ReadDataM); end
        ALUOutM = 32'h10; #1;
        n_checks++;
        if (ReadDataM !== 32'h1234_5678) begin n_errors++; $display("FAIL mid_ram got %h exp %h", ReadDataM, 32'h1234_5678); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram();
        test_fifo_order();
        test_full_push_pop();
        test_random_traffic();
        test_cycle();
        test_err();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
